pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_stage.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with an optional second skid entry.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid buffer, which gives a registered
// in_ready. Without it the stage holds a single entry, and in_ready is
// !out_valid | out_ready.
// The ctrl payload is kept at zero in any slot that holds no entry, so
// out_ctrl reads 0 whenever out_valid is low.
module pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         occupancy_q, occupancy_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [ADDR_W-1:0]  main_addr_q, main_addr_d;

  // Flush discards any entry offered in the same cycle.
  logic accept;
  logic pop;

  assign pop    = out_valid_q & out_ready;
  assign accept = in_valid & in_ready & ~flush;

  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

`ifdef PIPE_STAGE_SKID_EN

  logic               in_ready_q, in_ready_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [ADDR_W-1:0]  skid_addr_q, skid_addr_d;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready = in_ready_q;

  // Next-state and payload movement for the EMPTY/ONE/FULL skid buffer.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_addr_d = main_addr_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_addr_d = skid_addr_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          main_addr_d = in_addr;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          main_addr_d = in_addr;
        end else if (accept) begin
          state_d     = FULL;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          skid_addr_d = in_addr;
        end else if (pop) begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (pop) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          main_addr_d = skid_addr_q;
          skid_ctrl_d = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end
    out_valid_d = (state_d != EMPTY);
    occupancy_d = occ_of(state_d);
    in_ready_d  = (state_d != FULL);
  end

  // State, payload and registered status outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_addr_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      occupancy_q <= occupancy_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      main_addr_q <= main_addr_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_addr_q <= skid_addr_d;
    end
  end

`else

  // Single register: a held entry may be replaced in the same cycle it drains.
  assign in_ready = ~out_valid_q | out_ready;

  // Next-state and payload movement for the single-entry EMPTY/ONE stage.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_addr_d = main_addr_q;
    case (state_q)
      EMPTY, ONE: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          main_addr_d = in_addr;
        end else if (pop) begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
    end
    out_valid_d = (state_d != EMPTY);
    occupancy_d = occ_of(state_d);
  end

  // State, payload and registered status outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      occupancy_q <= occupancy_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      main_addr_q <= main_addr_d;
    end
  end

`endif

  assign out_valid = out_valid_q;
  assign occupancy = occupancy_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_addr  = main_addr_q;

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed vectors for pipe_stage with a queue scoreboard.
// Expected entries are queued as they are offered; the monitor pops and
// compares on every downstream transfer.
module tb_pipe_stage;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int AW = 5;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [AW-1:0] a;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [AW-1:0] in_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [AW-1:0] out_addr;
  logic [1:0]    occupancy;

  ent_t exp_q[$];
  ent_t e;
  int   errors = 0;
  int   checks = 0;

  pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_addr(out_addr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic [AW-1:0] a);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    in_addr  = a;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic [AW-1:0] a);
    exp_q.push_back('{d: d, c: c, a: a});
  endtask

  // Monitor: idle ctrl must be zero; every real downstream transfer is scored.
  always @(negedge clk) begin
    if (!out_valid) chk("ctrl_idle", 64'(out_ctrl), 64'h0);
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
        chk("out_addr", 64'(out_addr), 64'(e.a));
      end
    end
  end

  initial begin
    // Reset for two cycles.
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_occ", 64'(occupancy), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_ctrl", 64'(out_ctrl), 64'h0);
    chk("rst_addr", 64'(out_addr), 64'h0);

    // Stream 0x10..0x12 with out_ready high: one-cycle latency, occupancy 1.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h10 + i, 8'h01 + 8'(i), 5'(i));
      push(32'h10 + i, 8'h01 + 8'(i), 5'(i));
      tick();
      chk("stream_valid", 64'(out_valid), 64'h1);
      chk("stream_occ", 64'(occupancy), 64'h1);
      chk("stream_data", 64'(out_data), 64'h10 + i);
    end
    drive(1'b0, '0, '0, '0);
    tick();
    chk("stream_drain_valid", 64'(out_valid), 64'h0);
    chk("stream_drain_occ", 64'(occupancy), 64'h0);

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure: A0, A1 fill the stage; A2 waits until it is re-presented.
    out_ready = 1'b0;
    drive(1'b1, 32'hA0, 8'h21, 5'd3); push(32'hA0, 8'h21, 5'd3); tick();
    drive(1'b1, 32'hA1, 8'h22, 5'd4); push(32'hA1, 8'h22, 5'd4); tick();
    chk("bp_occ_full", 64'(occupancy), 64'h2);
    chk("bp_in_ready", 64'(in_ready), 64'h0);
    drive(1'b1, 32'hA2, 8'h23, 5'd5); tick();
    chk("bp_occ_hold", 64'(occupancy), 64'h2);
    chk("bp_stable", 64'(out_data), 64'hA0);
    out_ready = 1'b1;
    tick();
    chk("bp_occ_drain", 64'(occupancy), 64'h1);
    chk("bp_in_ready_back", 64'(in_ready), 64'h1);
    push(32'hA2, 8'h23, 5'd5);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    chk("bp_occ_empty", 64'(occupancy), 64'h0);
`else
    // Backpressure: in_ready follows out_ready combinationally while an entry is held.
    out_ready = 1'b0;
    drive(1'b1, 32'hB0, 8'h31, 5'd6); push(32'hB0, 8'h31, 5'd6); tick();
    chk("bp_in_ready_low", 64'(in_ready), 64'h0);
    chk("bp_occ", 64'(occupancy), 64'h1);
    drive(1'b1, 32'hB1, 8'h32, 5'd7); tick();
    chk("bp_stable", 64'(out_data), 64'hB0);
    chk("bp_occ_max", 64'(occupancy), 64'h1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 64'(in_ready), 64'h1);
    push(32'hB1, 8'h32, 5'd7); tick();
    chk("tp_b1", 64'(out_data), 64'hB1);
    drive(1'b1, 32'hB2, 8'h33, 5'd8); push(32'hB2, 8'h33, 5'd8); tick();
    drive(1'b1, 32'hB3, 8'h34, 5'd9); push(32'hB3, 8'h34, 5'd9); tick();
    chk("tp_b3", 64'(out_data), 64'hB3);
    chk("tp_occ", 64'(occupancy), 64'h1);
    drive(1'b0, '0, '0, '0); tick();
    chk("bp_occ_empty", 64'(occupancy), 64'h0);
`endif

    // Flush with ctrl 0xFF held; the entry offered alongside flush is dropped.
    out_ready = 1'b0;
    drive(1'b1, 32'hE0, 8'hFF, 5'd11); tick();
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b1, 32'hE1, 8'hFF, 5'd12); tick();
    chk("flush_pre_occ", 64'(occupancy), 64'h2);
`else
    chk("flush_pre_occ", 64'(occupancy), 64'h1);
`endif
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hE2, 8'hFF, 5'd13); tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_ctrl", 64'(out_ctrl), 64'h0);
    chk("flush_occ", 64'(occupancy), 64'h0);
    chk("flush_in_ready", 64'(in_ready), 64'h1);
    // Fresh entry after flush.
    drive(1'b1, 32'hF0, 8'h41, 5'd14); push(32'hF0, 8'h41, 5'd14); tick();
    drive(1'b0, '0, '0, '0); tick();

    // Reset with the stage as full as this build allows.
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD0001, 8'h51, 5'd15); tick();
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b1, 32'hDEAD0002, 8'h52, 5'd16); tick();
    chk("mrst_pre_occ", 64'(occupancy), 64'h2);
`else
    chk("mrst_pre_occ", 64'(occupancy), 64'h1);
`endif
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD0003, 8'h53, 5'd17); tick();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("mrst_valid", 64'(out_valid), 64'h0);
    chk("mrst_data", 64'(out_data), 64'h0);
    chk("mrst_ctrl", 64'(out_ctrl), 64'h0);
    chk("mrst_addr", 64'(out_addr), 64'h0);
    chk("mrst_occ", 64'(occupancy), 64'h0);
    chk("mrst_in_ready", 64'(in_ready), 64'h1);

    repeat (2) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
